mrr_frame_gen: RTL
==================

Name: mrr_frame_gen

Overview:
- Transmit-side frame synthesiser for the MRR gateway. It emits the power-domain sample stream a sensor node's pulse train produces.
- Frame content: a lead-in floor, a 16-symbol header pulse train (all '0'), the 15-bit PN sync sequence, then up to 64 payload bits.
- Drives AXI-stream plus a replay-flag framing output, so it can feed the gateway correlator/decoder chain in loopback and bench builds.

Parameters:
- ESAMP_WIDTH, 16, sample width.
- OVERSAMPLING_RATIO_LOG2, 2, log2 of samples per chip; pulse width PW = 1<<OVERSAMPLING_RATIO_LOG2.
- HEADER_LEN, 16, number of header symbols.
- PN_LEN, 15, PN sequence length.
- PN_SEQ, 15'b000100110101111, PN bits, sent MSB first.
- PAYLOAD_MAX_LOG2, 6, maximum payload bits = 64.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  one-cycle frame request; ignored unless idle.
- i_recharge_len  in  15  symbol period control; sampled at start.
- i_lead_len  in  16  floor samples emitted before the header; sampled at start.
- i_pulse_amp  in  ESAMP_WIDTH  sample value inside a pulse.
- i_floor  in  ESAMP_WIDTH  sample value outside a pulse.
- i_payload  in  64  payload bits, bit[len-1] sent first; sampled at start.
- i_payload_len  in  7  payload bit count, 0..64; values >64 clamp to 64.
- i_max_jitter  in  8  jitter bound; used only with the optional feature.
- o_tready  in  1  downstream ready.
- o_tvalid  out  1  sample valid.
- o_tdata  out  ESAMP_WIDTH  sample.
- o_tkeep  out  1  equals o_tvalid.
- o_tlast  out  1  last sample of the frame.
- o_replay_flag  out  1  high from the first header sample to the last frame sample.
- o_busy  out  1  high when not IDLE.
- o_done  out  1  one-cycle pulse after the last sample handshakes.

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0.
- Period P = (i_recharge_len+2)<<OVERSAMPLING_RATIO_LOG2 samples, computed in 17+OVERSAMPLING_RATIO_LOG2 bits. Minimum P = 8 with defaults.
- Symbol encoding is PPM:
  - bit 0: pulse occupies samples [0, PW) of the period.
  - bit 1: pulse occupies samples [P/2, P/2+PW).
  - all other samples = i_floor.
- Header symbols are all bit 0, then the PN_SEQ bits, then payload bits.
- Handshake:
  - Counters advance only on o_tvalid & o_tready.
  - o_tdata and o_tlast are held stable while stalled.
  - o_tvalid is registered and rises the cycle after leaving IDLE.
- States:
  - IDLE: i_start latches config and goes to LEAD, or to HEADER when i_lead_len=0.
  - LEAD: emits i_floor for i_lead_len samples, then HEADER. o_replay_flag = 0.
  - HEADER: HEADER_LEN periods, then PN.
  - PN: PN_LEN periods, then PAYLOAD, or DONE when payload_len = 0.
  - PAYLOAD: payload_len periods, then DONE.
  - DONE: one cycle, o_done = 1, return to IDLE.
- o_tlast is set on sample P-1 of the final symbol.
- Latency: first sample is valid 1 cycle after i_start. Back-to-back frames leave a gap of at least 2 idle cycles.
- i_start while busy: ignored, no queueing.
- Config inputs change mid-frame: no effect, because latched values are used.
- rst_n asserted mid-frame: immediate return to IDLE with outputs 0. No o_done, no o_tlast.
- Sample counter wraps to 0 at P-1; the symbol counter increments at that wrap.

Optional Feature:
- Macro: MRR_PULSE_JITTER_EN.
- Defined:
  - A 16-bit Galois LFSR (seed 16'hACE1, reset to seed, steps once per symbol) produces delay d = lfsr[7:0] mod (i_max_jitter+1).
  - d saturates at P/2-PW.
  - Each pulse is shifted late by d samples within its slot.
  - i_max_jitter=0 gives output identical to the non-jitter build.
- Undefined: no LFSR, d = 0, i_max_jitter unused.

Decomposition:
- Shared package mrr_params.vh holds ESAMP_WIDTH, OVERSAMPLING_RATIO_LOG2, HEADER_LEN, PN_LEN, PN_SEQ and state encodings.
- One sub-module, mrr_ppm_symbol_gen: takes period, bit, jitter and the handshake, and produces per-sample pulse/floor plus an end-of-symbol strobe.
- The top level holds the frame FSM and bit sequencing.

Test Plan:
- Basic frame: recharge_len=0, lead=4, payload_len=0, amp=100, floor=5, tready=1.
  - 4 floor samples, then 31 symbols of 8 samples.
  - Header pulses at sample offsets 0..3.
  - PN bit1 symbols have pulses at offsets 4..7.
  - o_tlast on sample 4+248-1; o_done one cycle after.
- Payload ordering: payload_len=3, i_payload=3'b101 → last three symbols are PPM 1, 0, 1.
- Backpressure: tready toggles 1,0,0,1 → identical sample sequence; data stable during stalls.
- Restart and clamp: i_start during a frame is ignored; payload_len=100 yields exactly 64 payload symbols.
- Reset mid-frame: rst_n low at sample 50 → all outputs 0 next edge. A following i_start produces a correct full frame.
- Jitter build: max_jitter=0 matches the reference bench trace. max_jitter=255 with P=8 keeps every pulse inside its 4-sample half-slot (d≤0).

Source files
------------

// File: rtl/mrr_frame_gen_pkg.sv
// Shared constants, state encoding and period helper for the MRR frame generator.
// Optional pulse jitter is enabled by defining MRR_PULSE_JITTER_EN.
package mrr_frame_gen_pkg;

    localparam int ESAMP_WIDTH             = 16;
    localparam int OVERSAMPLING_RATIO_LOG2 = 2;
    localparam int PW                      = 1 << OVERSAMPLING_RATIO_LOG2;
    localparam int PERIOD_WIDTH            = 17 + OVERSAMPLING_RATIO_LOG2;
    localparam int HEADER_LEN              = 16;
    localparam int PN_LEN                  = 15;
    localparam logic [PN_LEN-1:0] PN_SEQ   = 15'b000100110101111;
    localparam int PAYLOAD_MAX_LOG2        = 6;
    localparam int PAYLOAD_MAX             = 1 << PAYLOAD_MAX_LOG2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEAD,
        ST_HEADER,
        ST_PN,
        ST_PAYLOAD,
        ST_DONE
    } state_e;

    function automatic logic [PERIOD_WIDTH-1:0] period_of(input logic [14:0] recharge_len);
        logic [PERIOD_WIDTH-1:0] p;
        p = PERIOD_WIDTH'({2'b00, recharge_len}) + PERIOD_WIDTH'(2);
        return p << OVERSAMPLING_RATIO_LOG2;
    endfunction

endpackage

// File: rtl/mrr_frame_gen_ppm_symbol_gen.sv
// PPM symbol sample generator: tracks the sample index inside a symbol period and
// decides pulse/floor for the next sample. MRR_PULSE_JITTER_EN adds LFSR pulse delay.
module mrr_ppm_symbol_gen
    import mrr_frame_gen_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [PERIOD_WIDTH-1:0] i_period,
    input  logic [7:0]              i_max_jitter,
    input  logic                    i_load,
    input  logic                    i_step,
    input  logic                    i_bit_nxt,
    output logic                    o_eos,
    output logic                    o_pulse_nxt,
    output logic                    o_last_nxt
);

    localparam logic [PERIOD_WIDTH-1:0] ONE = PERIOD_WIDTH'(1);

    logic [PERIOD_WIDTH-1:0] samp_q, samp_d;
    logic [PERIOD_WIDTH-1:0] half, pos, delay;
    logic                    sym_wrap;

    assign half     = i_period >> 1;
    assign o_eos    = (samp_q == i_period - ONE);
    assign sym_wrap = i_step & o_eos;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        samp_d = samp_q;
        if (i_load) begin
            samp_d = '0;
        end else if (i_step) begin
            samp_d = o_eos ? '0 : samp_q + ONE;
        end
    end

`ifdef MRR_PULSE_JITTER_EN
    logic [15:0]             lfsr_q, lfsr_nxt;
    logic [7:0]              jit_byte;
    logic [8:0]              jit_raw;
    logic [PERIOD_WIDTH-1:0] jit_lim;

    assign lfsr_nxt = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    // The delay for a new symbol comes from the LFSR value it steps into.
    assign jit_byte = sym_wrap ? lfsr_nxt[7:0] : lfsr_q[7:0];
    assign jit_raw  = {1'b0, jit_byte} % ({1'b0, i_max_jitter} + 9'd1);
    assign jit_lim  = half - PERIOD_WIDTH'(PW);
    assign delay    = (PERIOD_WIDTH'(jit_raw) > jit_lim) ? jit_lim : PERIOD_WIDTH'(jit_raw);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= 16'hACE1;
        end else if (sym_wrap) begin
            lfsr_q <= lfsr_nxt;
        end
    end
`else
    logic unused_max_jitter;
    assign unused_max_jitter = ^i_max_jitter;
    assign delay             = '0;
`endif

    assign pos         = i_bit_nxt ? half + delay : delay;
    assign o_pulse_nxt = (samp_d >= pos) && (samp_d < pos + PERIOD_WIDTH'(PW));
    assign o_last_nxt  = (samp_d == i_period - ONE);

    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_q <= '0;
        end else begin
            samp_q <= samp_d;
        end
    end

endmodule

// File: rtl/mrr_frame_gen.sv
// MRR transmit frame synthesiser: lead-in floor, header, PN sync and payload as a
// PPM sample stream on AXI-stream. Optional jitter via MRR_PULSE_JITTER_EN.
module mrr_frame_gen
    import mrr_frame_gen_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_start,
    input  logic [14:0]            i_recharge_len,
    input  logic [15:0]            i_lead_len,
    input  logic [ESAMP_WIDTH-1:0] i_pulse_amp,
    input  logic [ESAMP_WIDTH-1:0] i_floor,
    input  logic [63:0]            i_payload,
    input  logic [6:0]             i_payload_len,
    input  logic [7:0]             i_max_jitter,
    input  logic                   o_tready,
    output logic                   o_tvalid,
    output logic [ESAMP_WIDTH-1:0] o_tdata,
    output logic                   o_tkeep,
    output logic                   o_tlast,
    output logic                   o_replay_flag,
    output logic                   o_busy,
    output logic                   o_done
);

    state_e                  state_q, state_n;
    logic [6:0]              sym_q, sym_n, last_sym;
    logic [15:0]             lead_q, lead_n, lead_len_q;
    logic [PERIOD_WIDTH-1:0] period_q, period_sel;
    logic [63:0]             payload_q;
    logic [6:0]              payload_len_q, payload_len_in;
    logic [ESAMP_WIDTH-1:0]  amp_q, floor_q, amp_sel, floor_sel;
    logic [ESAMP_WIDTH-1:0]  tdata_q, tdata_nxt;
    logic                    tvalid_q, tlast_q, replay_q, busy_q, done_q;
    logic                    adv, load, step, eos, pulse_nxt, last_nxt;
    logic                    bit_nxt, sym_state_n, stream_n, tlast_nxt;
    logic [3:0]              pn_idx;
    logic [5:0]              pay_idx;

    assign adv            = tvalid_q & o_tready;
    assign load           = (state_q == ST_IDLE) & i_start;
    assign payload_len_in = (i_payload_len > 7'(PAYLOAD_MAX)) ? 7'(PAYLOAD_MAX) : i_payload_len;

    // The first sample is computed from the live inputs while they are being latched.
    assign period_sel = load ? period_of(i_recharge_len) : period_q;
    assign amp_sel    = load ? i_pulse_amp : amp_q;
    assign floor_sel  = load ? i_floor : floor_q;

    always_comb begin
        case (state_q)
            ST_HEADER: last_sym = 7'(HEADER_LEN - 1);
            ST_PN:     last_sym = 7'(PN_LEN - 1);
            default:   last_sym = payload_len_q - 7'd1;
        endcase
    end

    always_comb begin
        state_n = state_q;
        sym_n   = sym_q;
        lead_n  = lead_q;
        step    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    state_n = (i_lead_len == 16'd0) ? ST_HEADER : ST_LEAD;
                    sym_n   = '0;
                    lead_n  = '0;
                end
            end
            ST_LEAD: begin
                if (adv) begin
                    if (lead_q == lead_len_q - 16'd1) begin
                        state_n = ST_HEADER;
                        sym_n   = '0;
                    end else begin
                        lead_n = lead_q + 16'd1;
                    end
                end
            end
            ST_HEADER, ST_PN, ST_PAYLOAD: begin
                if (adv) begin
                    step = 1'b1;
                    if (eos) begin
                        if (sym_q == last_sym) begin
                            sym_n = '0;
                            if (state_q == ST_HEADER) begin
                                state_n = ST_PN;
                            end else if (state_q == ST_PN && payload_len_q != 7'd0) begin
                                state_n = ST_PAYLOAD;
                            end else begin
                                state_n = ST_DONE;
                            end
                        end else begin
                            sym_n = sym_q + 7'd1;
                        end
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign sym_state_n = (state_n == ST_HEADER) || (state_n == ST_PN) || (state_n == ST_PAYLOAD);
    assign stream_n    = sym_state_n || (state_n == ST_LEAD);
    assign pn_idx      = 4'(PN_LEN - 1) - sym_n[3:0];
    assign pay_idx     = 6'(payload_len_q - 7'd1 - sym_n);

    always_comb begin
        case (state_n)
            ST_PN:      bit_nxt = PN_SEQ[pn_idx];
            ST_PAYLOAD: bit_nxt = payload_q[pay_idx];
            default:    bit_nxt = 1'b0;
        endcase
    end

    assign tdata_nxt = !stream_n ? '0 : (sym_state_n && pulse_nxt) ? amp_sel : floor_sel;
    assign tlast_nxt = last_nxt &&
                       (((state_n == ST_PAYLOAD) && (sym_n == payload_len_q - 7'd1)) ||
                        ((state_n == ST_PN) && (sym_n == 7'(PN_LEN - 1)) && (payload_len_q == 7'd0)));

    mrr_ppm_symbol_gen u_sym (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_period     (period_sel),
        .i_max_jitter (i_max_jitter),
        .i_load       (load),
        .i_step       (step),
        .i_bit_nxt    (bit_nxt),
        .o_eos        (eos),
        .o_pulse_nxt  (pulse_nxt),
        .o_last_nxt   (last_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            sym_q         <= '0;
            lead_q        <= '0;
            lead_len_q    <= '0;
            period_q      <= '0;
            payload_q     <= '0;
            payload_len_q <= '0;
            amp_q         <= '0;
            floor_q       <= '0;
            tvalid_q      <= 1'b0;
            tdata_q       <= '0;
            tlast_q       <= 1'b0;
            replay_q      <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q <= state_n;
            sym_q   <= sym_n;
            lead_q  <= lead_n;
            busy_q  <= (state_n != ST_IDLE);
            done_q  <= (state_n == ST_DONE);
            if (load) begin
                lead_len_q    <= i_lead_len;
                period_q      <= period_of(i_recharge_len);
                payload_q     <= i_payload;
                payload_len_q <= payload_len_in;
                amp_q         <= i_pulse_amp;
                floor_q       <= i_floor;
            end
            // Output registers only move on a handshake, so they hold while stalled.
            if (load || adv) begin
                tvalid_q <= stream_n;
                tdata_q  <= tdata_nxt;
                tlast_q  <= tlast_nxt;
                replay_q <= sym_state_n;
            end
        end
    end

    assign o_tvalid      = tvalid_q;
    assign o_tkeep       = tvalid_q;
    assign o_tdata       = tdata_q;
    assign o_tlast       = tlast_q;
    assign o_replay_flag = replay_q;
    assign o_busy        = busy_q;
    assign o_done        = done_q;

endmodule
